// File: rtl/hammer_drive_if.sv
// Bar-address strobe and hammer-drive bundle for hammer_drive.
// The master drives the bar/strobe inputs and the slave (the driver) returns hammer state.
interface hammer_drive_if #(
  parameter int unsigned COLUMNS = 132
) ();
  logic [4:0]       i_bar_units;
  logic [4:0]       i_bar_tens;
  logic             i_bar_100;
  logic             i_print_compare;
  logic             i_scan_start;
  logic             i_check_reset;
  logic [COLUMNS:1] o_hammer_fire;
  logic [COLUMNS:1] o_fired_map;
  logic [7:0]       o_fire_count;
  logic             o_busy;
  logic             o_check_code;
  logic             o_check_range;

  modport master (
    output i_bar_units, i_bar_tens, i_bar_100, i_print_compare, i_scan_start, i_check_reset,
    input  o_hammer_fire, o_fired_map, o_fire_count, o_busy, o_check_code, o_check_range
  );

  modport slave (
    input  i_bar_units, i_bar_tens, i_bar_100, i_print_compare, i_scan_start, i_check_reset,
    output o_hammer_fire, o_fired_map, o_fire_count, o_busy, o_check_code, o_check_range
  );
endinterface

// File: rtl/hammer_drive.sv
// Print-hammer driver: decodes the 2-of-5 bar address and fires one hammer per strobe.
// Define HAMMER_FIRED_MAP_EN to suppress a second fire of a column within one line scan.
module hammer_drive #(
  parameter int unsigned COLUMNS     = 132,
  parameter int unsigned FIRE_CYCLES = 8
) (
  input logic           i_clk,
  input logic           i_reset_n,
  hammer_drive_if.slave bus
);

  localparam logic [7:0] ColMax   = 8'(COLUMNS);
  localparam logic [7:0] FireLoad = 8'(FIRE_CYCLES);

  logic [4:0] units_q, tens_q;
  logic       hund_q, strobe_q, scan_q, chk_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      units_q  <= '0;
      tens_q   <= '0;
      hund_q   <= 1'b0;
      strobe_q <= 1'b0;
      scan_q   <= 1'b0;
      chk_q    <= 1'b0;
    end else begin
      units_q  <= bus.i_bar_units;
      tens_q   <= bus.i_bar_tens;
      hund_q   <= bus.i_bar_100;
      strobe_q <= bus.i_print_compare;
      scan_q   <= bus.i_scan_start;
      chk_q    <= bus.i_check_reset;
    end
  end

  // Returns {valid, digit}; every code with exactly two bits set maps to a digit.
  function automatic logic [4:0] decode_digit(input logic [4:0] code);
    logic [4:0] r;
    case (code)
      5'b00011: r = {1'b1, 4'd0};
      5'b10010: r = {1'b1, 4'd1};
      5'b10001: r = {1'b1, 4'd2};
      5'b01001: r = {1'b1, 4'd3};
      5'b11000: r = {1'b1, 4'd4};
      5'b10100: r = {1'b1, 4'd5};
      5'b01100: r = {1'b1, 4'd6};
      5'b01010: r = {1'b1, 4'd7};
      5'b00110: r = {1'b1, 4'd8};
      5'b00101: r = {1'b1, 4'd9};
      default:  r = 5'd0;
    endcase
    return r;
  endfunction

  logic       units_ok, tens_ok;
  logic [3:0] units_dig, tens_dig;
  logic [7:0] addr;
  logic       code_err, range_err, hit;

  assign {units_ok, units_dig} = decode_digit(units_q);
  assign {tens_ok, tens_dig}   = decode_digit(tens_q);

  assign addr = ({7'd0, hund_q} * 8'd100) + ({4'd0, tens_dig} * 8'd10) + {4'd0, units_dig};

  assign code_err  = strobe_q & ~(units_ok & tens_ok);
  assign range_err = strobe_q & units_ok & tens_ok & ((addr == 8'd0) || (addr > ColMax));
  assign hit       = strobe_q & units_ok & tens_ok & ~range_err;

  logic [COLUMNS:1][7:0] cnt_q, cnt_d;
  logic [COLUMNS:1]      map_clr, acc_vec, fire;
  logic [7:0]            count_q, count_d, count_base;
  logic                  code_q, range_q, accept;

`ifdef HAMMER_FIRED_MAP_EN
  logic [COLUMNS:1] map_q;

  // A scan start in the same clock clears the map before the strobe is judged.
  assign map_clr = scan_q ? '0 : map_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) map_q <= '0;
    else            map_q <= map_clr | acc_vec;
  end

  assign bus.o_fired_map = map_q;
`else
  assign map_clr         = '0;
  assign bus.o_fired_map = '0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    acc_vec = '0;
    fire    = '0;
    for (int unsigned n = 1; n <= COLUMNS; n++) begin
      fire[n] = (cnt_q[n] != 8'd0);
      if (cnt_q[n] != 8'd0) begin
        cnt_d[n] = cnt_q[n] - 8'd1;
      end else if (hit && (addr == 8'(n)) && !map_clr[n]) begin
        cnt_d[n]   = FireLoad;
        acc_vec[n] = 1'b1;
      end
    end
  end

  assign accept     = |acc_vec;
  assign count_base = scan_q ? 8'd0 : count_q;
  assign count_d    = (accept && (count_base != 8'hFF)) ? count_base + 8'd1 : count_base;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q   <= '0;
      count_q <= '0;
      code_q  <= 1'b0;
      range_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      count_q <= count_d;
      // A new error in the same clock as check_reset keeps the flag set.
      code_q  <= code_err | (code_q & ~chk_q);
      range_q <= range_err | (range_q & ~chk_q);
    end
  end

  assign bus.o_hammer_fire = fire;
  assign bus.o_busy        = |fire;
  assign bus.o_fire_count  = count_q;
  assign bus.o_check_code  = code_q;
  assign bus.o_check_range = range_q;

endmodule

// File: tb/tb_hammer_drive.sv
// Directed self-checking bench for hammer_drive (COLUMNS=132, FIRE_CYCLES=8).
module tb_hammer_drive;

  localparam int unsigned Cols = 132;
  localparam int unsigned Fc   = 8;
`ifdef HAMMER_FIRED_MAP_EN
  localparam bit MapEn = 1'b1;
`else
  localparam bit MapEn = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  logic [4:0] enc [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                           5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};

  hammer_drive_if #(.COLUMNS(Cols)) bus ();

  hammer_drive #(
    .COLUMNS     (Cols),
    .FIRE_CYCLES (Fc)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_n             = 1'b0;
    bus.i_bar_units     = '0;
    bus.i_bar_tens      = '0;
    bus.i_bar_100       = 1'b0;
    bus.i_print_compare = 1'b0;
    bus.i_scan_start    = 1'b0;
    bus.i_check_reset   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-clock strobe; returns at the negedge after the sampling edge.
  task automatic strobe_raw(input logic [4:0] u, input logic [4:0] t, input logic h,
                            input logic scan, input logic chk);
    @(negedge clk);
    bus.i_bar_units     = u;
    bus.i_bar_tens      = t;
    bus.i_bar_100       = h;
    bus.i_print_compare = 1'b1;
    bus.i_scan_start    = scan;
    bus.i_check_reset   = chk;
    @(negedge clk);
    bus.i_print_compare = 1'b0;
    bus.i_scan_start    = 1'b0;
    bus.i_check_reset   = 1'b0;
  endtask

  task automatic set_addr(input int unsigned a);
    bus.i_bar_100   = (a >= 100);
    bus.i_bar_tens  = enc[(a % 100) / 10];
    bus.i_bar_units = enc[a % 10];
  endtask

  task automatic strobe(input int unsigned a, input logic scan);
    strobe_raw(enc[a % 10], enc[(a % 100) / 10], a >= 100, scan, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (bus.o_hammer_fire !== '0 || bus.o_fired_map !== '0 || bus.o_fire_count !== 8'd0 ||
        bus.o_busy !== 1'b0 || bus.o_check_code !== 1'b0 || bus.o_check_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: fire=%h map=%h count=%0d busy=%b code=%b range=%b, need all 0",
               bus.o_hammer_fire, bus.o_fired_map, bus.o_fire_count, bus.o_busy,
               bus.o_check_code, bus.o_check_range);
    end
  endtask

  task automatic test_fire47();
    int highs, busy_highs;
    apply_reset();
    strobe(47, 1'b0);
    checks++;
    if (bus.o_hammer_fire[47] !== 1'b0) begin
      errors++;
      $display("FAIL fire47_latency: hammer=%b one clock early, need 0", bus.o_hammer_fire[47]);
    end
    highs = 0;
    busy_highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.o_hammer_fire[47] === 1'b1) highs++;
      if (bus.o_busy === 1'b1) busy_highs++;
      if (i == 0) begin
        checks++;
        if (bus.o_hammer_fire[47] !== 1'b1 || bus.o_fired_map[47] !== MapEn ||
            bus.o_fire_count !== 8'd1) begin
          errors++;
          $display("FAIL fire47_first: hammer=%b map=%b count=%0d, need 1 %b 1",
                   bus.o_hammer_fire[47], bus.o_fired_map[47], bus.o_fire_count, MapEn);
        end
      end
    end
    checks++;
    if (highs != 8 || busy_highs != 8) begin
      errors++;
      $display("FAIL fire47_width: hammer high %0d busy high %0d clocks, need 8 8",
               highs, busy_highs);
    end
    checks++;
    if ((bus.o_hammer_fire & ~(132'd1 << 46)) !== '0) begin
      errors++;
      $display("FAIL fire47_others: fire=%h, need only column 47", bus.o_hammer_fire);
    end
  endtask

  task automatic test_range();
    apply_reset();
    strobe(132, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_hammer_fire[132] !== 1'b1 || bus.o_check_range !== 1'b0) begin
      errors++;
      $display("FAIL range_132: hammer=%b range=%b, need 1 0",
               bus.o_hammer_fire[132], bus.o_check_range);
    end
    wait_clks(10);
    strobe(133, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_check_range !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_fire_count !== 8'd1) begin
      errors++;
      $display("FAIL range_133: range=%b busy=%b count=%0d, need 1 0 1",
               bus.o_check_range, bus.o_busy, bus.o_fire_count);
    end
    apply_reset();
    strobe(0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_check_range !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_check_code !== 1'b0) begin
      errors++;
      $display("FAIL range_0: range=%b busy=%b code=%b, need 1 0 0",
               bus.o_check_range, bus.o_busy, bus.o_check_code);
    end
  endtask

  task automatic test_bad_code();
    apply_reset();
    strobe_raw(5'b00111, enc[1], 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_check_code !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_check_range !== 1'b0) begin
      errors++;
      $display("FAIL bad_code_set: code=%b busy=%b range=%b, need 1 0 0",
               bus.o_check_code, bus.o_busy, bus.o_check_range);
    end
    bus.i_check_reset = 1'b1;
    @(negedge clk);
    bus.i_check_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_check_code !== 1'b0) begin
      errors++;
      $display("FAIL bad_code_clear: code=%b, need 0", bus.o_check_code);
    end
    strobe_raw(enc[3], 5'b00001, 1'b0, 1'b0, 1'b0);
    wait_clks(2);
    strobe_raw(5'b11100, enc[2], 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_check_code !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_code_wins: code=%b busy=%b, need 1 0", bus.o_check_code, bus.o_busy);
    end
  endtask

  task automatic test_duplicate();
    apply_reset();
    strobe(12, 1'b0);
    wait_clks(20);
    strobe(12, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_hammer_fire[12] !== !MapEn || bus.o_fire_count !== (MapEn ? 8'd1 : 8'd2)) begin
      errors++;
      $display("FAIL dup_second: hammer=%b count=%0d, need %b %0d", bus.o_hammer_fire[12],
               bus.o_fire_count, !MapEn, MapEn ? 1 : 2);
    end
    wait_clks(10);
    @(negedge clk);
    bus.i_scan_start = 1'b1;
    @(negedge clk);
    bus.i_scan_start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_fire_count !== 8'd0 || bus.o_fired_map !== '0) begin
      errors++;
      $display("FAIL dup_scan_clear: count=%0d map=%h, need 0 0",
               bus.o_fire_count, bus.o_fired_map);
    end
    strobe(12, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_hammer_fire[12] !== 1'b1 || bus.o_fire_count !== 8'd1) begin
      errors++;
      $display("FAIL dup_after_scan: hammer=%b count=%0d, need 1 1",
               bus.o_hammer_fire[12], bus.o_fire_count);
    end
    wait_clks(10);
    strobe(12, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_hammer_fire[12] !== 1'b1 || bus.o_fire_count !== 8'd1 ||
        bus.o_fired_map[12] !== MapEn) begin
      errors++;
      $display("FAIL dup_scan_same_clk: hammer=%b count=%0d map=%b, need 1 1 %b",
               bus.o_hammer_fire[12], bus.o_fire_count, bus.o_fired_map[12], MapEn);
    end
  endtask

  task automatic test_back_to_back();
    int busy_highs, overlap;
    apply_reset();
    @(negedge clk);
    set_addr(5);
    bus.i_print_compare = 1'b1;
    @(negedge clk);
    set_addr(6);
    @(negedge clk);
    busy_highs = 0;
    overlap    = 0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.o_busy === 1'b1) busy_highs++;
      if (bus.o_hammer_fire[5] === 1'b1 && bus.o_hammer_fire[6] === 1'b1) overlap++;
      bus.i_print_compare = 1'b0;
    end
    checks++;
    if (busy_highs != 9 || overlap != 7 || bus.o_fire_count !== 8'd2) begin
      errors++;
      $display("FAIL back_to_back: busy %0d overlap %0d count %0d, need 9 7 2",
               busy_highs, overlap, bus.o_fire_count);
    end
  endtask

  task automatic test_reset_mid_fire();
    apply_reset();
    strobe(47, 1'b0);
    wait_clks(3);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.o_hammer_fire !== '0 || bus.o_busy !== 1'b0 || bus.o_fire_count !== 8'd0 ||
        bus.o_fired_map !== '0) begin
      errors++;
      $display("FAIL reset_mid_fire: fire=%h busy=%b count=%0d map=%h, need all 0",
               bus.o_hammer_fire, bus.o_busy, bus.o_fire_count, bus.o_fired_map);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fire47();
    test_range();
    test_bad_code();
    test_duplicate();
    test_back_to_back();
    test_reset_mid_fire();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hammer_drive.md
# hammer_drive

Parametrised print-hammer driver for the printer adapter. It decodes the 2-of-5 units/tens bar address plus the hundreds bit on each print-compare strobe. It then fires the selected hammer for a programmable number of clocks and tracks which hammers have fired during the current line scan, so a column is never struck twice per line. It also flags malformed bar codes and out-of-range addresses.

## Interface
Parameters:
- COLUMNS, 132, number of print positions (1..199).
- FIRE_CYCLES, 8, clocks each hammer output stays asserted (1..255).

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_bar_units  in  5  units digit, 2-of-5 code (bits 4..0).
- i_bar_tens  in  5  tens digit, 2-of-5 code.
- i_bar_100  in  1  hundreds bit (adds 100).
- i_print_compare  in  1  print compare; requests a fire at the bar address.
- i_scan_start  in  1  start of line scan; clears fired map and count.
- i_check_reset  in  1  clears sticky check flags.
- o_hammer_fire  out  [COLUMNS:1]  hammer drive, one bit per column.
- o_fired_map  out  [COLUMNS:1]  columns fired since last scan start.
- o_fire_count  out  8  number of fires since last scan start, saturates at 255.
- o_busy  out  1  any hammer currently firing.
- o_check_code  out  1  sticky: a strobed digit was not exactly 2-of-5.
- o_check_range  out  1  sticky: a strobed address was 0 or greater than COLUMNS.

## Operation
- Stage 1 registers the bar inputs, print_compare, scan_start and check_reset every clock.
- Digit decode uses the 2-of-5 map, one pair of set bits per digit:
  - 0={1,0}, 1={4,1}, 2={4,0}, 3={3,0}, 4={4,3}
  - 5={4,2}, 6={3,2}, 7={3,1}, 8={2,1}, 9={2,0}
- Address = 100*bar_100 + 10*tens + units.
- Validity and check flags on a registered strobe:
  - A digit is valid only if exactly two bits are set. Otherwise set o_check_code and do not fire.
  - Address 0 or address > COLUMNS sets o_check_range and does not fire.
- Valid strobe at column n:
  - If n is idle and (map enabled) not yet in the fired map, load its counter with FIRE_CYCLES.
  - Set fired_map[n] and increment o_fire_count.
  - If n is already firing, ignore the strobe: no reload and no count.
  - If n is already in the map, ignore the strobe.
- Each column has its own down-counter, so several hammers may fire concurrently. o_hammer_fire[n] = (counter[n] != 0).
- Registered scan_start clears o_fired_map and o_fire_count.
  - Simultaneous with a valid strobe: clear first, then apply the strobe. The fire counts as the first fire of the new scan.
  - Scan start does not truncate hammers already firing.
- Registered check_reset clears both check flags. A simultaneous new error wins, so the flag stays set.
- o_busy = OR of all o_hammer_fire bits.

## Timing
- Reset (async assert, sync release) clears all of the following:
  - all counters, so o_hammer_fire is 0
  - o_fired_map = 0, o_fire_count = 0
  - o_busy = 0, both check flags = 0, stage-1 registers
- Latency: inputs sampled at edge k; o_hammer_fire[n] rises after edge k+1 and stays high exactly FIRE_CYCLES clocks.
- Check flags and fired map update after edge k+1.
- i_print_compare held high for several clocks is one strobe per clock. With the fired map enabled, only the first strobe fires.
- Reset asserted mid-fire drops all outputs immediately.

## Configuration
- HAMMER_FIRED_MAP_EN defined:
  - fired map is maintained and suppresses a second fire of the same column within a scan.
  - o_fired_map and o_fire_count operate as above.
- Not defined:
  - o_fired_map is tied to 0 and o_fire_count counts every accepted fire.
  - A column may re-fire within a scan once its counter has reached 0.
  - i_scan_start clears only o_fire_count.

## Test plan
- Fire column 47: after reset, units=7 (01010), tens=4 (11000), bar_100=0, one-clock strobe.
  - o_hammer_fire[47] high from the edge after the strobe is registered, for 8 clocks.
  - o_fired_map[47]=1, o_fire_count=1, o_busy tracks the hammer.
- Upper bound, COLUMNS=132:
  - Address 132 (100 + tens 3 + units 2) fires column 132.
  - Address 133 sets o_check_range, nothing fires.
  - Address 0 sets o_check_range.
- Bad code: units=00111 sets o_check_code with no fire. i_check_reset clears it, unless the same clock carries another bad strobe.
- Duplicate strobe to column 12, map enabled:
  - Strobe, then strobe again 20 clocks later: second strobe ignored, count stays 1.
  - After i_scan_start, a further strobe fires again and count=1.
  - Map disabled: the second strobe fires and count=2.
- Concurrent fires: strobe columns 5 and 6 on consecutive clocks. Both hammers overlap for 7 clocks, o_busy is high for 9 clocks, count=2.
- Reset mid-fire: assert i_reset_n low 3 clocks into a fire. All outputs are 0 immediately, without waiting for a clock edge.
